ustc_fan: RTL and testbench
===========================

USTC_FAN -- requirements
Module: ustc_fan

Interface
REQ-001 Parameter DW_DATA, default 8: data field width per lane.
REQ-002 Parameter DW_ROW, default 4: row-id field width per lane.
REQ-003 Parameter DW_CTRL, default 4: control field width per lane.
REQ-004 Parameter DW_LINE, default DW_DATA+DW_ROW+DW_CTRL (16): lane width.
REQ-005 Parameter NUM_IN, default 32: lane count, power of two.
REQ-006 Parameter N_LEVELS, default 5: adder-tree depth, log2(NUM_IN).
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 in  input  NUM_IN*DW_LINE  lane i occupies bits [i*DW_LINE +: DW_LINE].
REQ-010 out  output  NUM_IN*DW_LINE  result lanes, same packing as in.
REQ-011 Lane format SHALL be {ctrl[DW_CTRL-1:0], row[DW_ROW-1:0], data[DW_DATA-1:0]}, MSB first.
REQ-012 ctrl bit meanings SHALL be: bit3 valid, bit2 reserved (ignored), bit1 group start, bit0 group end.

Function
REQ-013 Block SHALL perform segmented (forwarding-adder-network) reduction: sum data of each group of contiguous lanes, one full vector per cycle.
REQ-014 A group SHALL begin at a valid lane with start=1 and extend toward lower lane indices, up to and including the first lane with end=1.
REQ-015 A lane with start=1 and end=1 SHALL form a single-lane group.
REQ-016 A group with no end flag SHALL close at lane 0.
REQ-017 Lanes inside a group with valid=0 SHALL contribute 0 to the sum.
REQ-018 Valid lanes outside any group SHALL be ignored.
REQ-019 A start flag inside an open group SHALL close the previous group at the lane above and open a new group.
REQ-020 Row-id SHALL NOT affect grouping.
REQ-021 Data SHALL be unsigned; sums SHALL be computed modulo 2^DW_DATA (wrap, no saturation).
REQ-022 Result for a group SHALL appear on the group's start lane as {ctrl=4'b1000, row=start lane's row, data=sum}.
REQ-023 Every other output lane SHALL be all zeros.
REQ-024 Latency SHALL be exactly N_LEVELS cycles: a vector sampled at rising edge k appears on out after edge k+N_LEVELS-1 and holds for one cycle.
REQ-025 Pipeline SHALL be fully pipelined (throughput one vector/cycle); consecutive vectors SHALL NOT interact.
REQ-026 out SHALL be driven directly from registers (no combinational path in->out).

Reset
REQ-027 While rst=1 at a clock edge, all pipeline registers and out SHALL be cleared to 0.
REQ-028 Vectors in flight when rst asserts SHALL be discarded; out SHALL stay 0 until the first vector sampled after rst deasserts emerges N_LEVELS cycles later.

Verification
REQ-029 Reset: rst=1 for 1 cycle, in=0 -> out=0 on every lane.
REQ-030 Descending groups: lanes 31..29 row0 data 31..29, 28..23 row1, 22..19 row2, 18..8 row3, 7..0 row4, data=lane index, start on top lane, end on bottom lane -> after 5 cycles: lane31={1000,0,90}, lane28={1000,1,153}, lane22={1000,2,82}, lane18={1000,3,143}, lane7={1000,4,28}; all other lanes 0.
REQ-031 Back-to-back: on the next cycle, lanes 31..24 row4 data 0..7, 23..13 row3 data 8..18, 12..9 row2 data 19..22, 8..3 row1 data 23..28, 2..0 row0 data 29..31 -> one cycle after the REQ-030 result: lane31=28, lane23=143, lane12=82, lane8=153, lane2=90, with matching rows; no cross-contamination with the REQ-030 vector.
REQ-032 Overflow: a single group over all 32 lanes (start lane31, end lane0), each data 0xFF -> lane31 data=0xE0.
REQ-033 Singletons and invalid lanes: every lane ctrl=1011 with data=i -> out lane i data=i. Same vector with ctrl=0000 -> all lanes 0.
REQ-034 Mid-stream reset: assert rst while 3 vectors are in flight -> out=0 throughout and after; no stale result emerges.

Source files
------------

// File: rtl/ustc_fan.sv
// ustc_fan: segmented lane reduction built as a pipelined forwarding-adder
// network. Each level doubles the reach of every lane's running sum toward
// lane 0, stopping at segment boundaries, so after log2(NUM_IN) levels each
// group's start lane holds the sum of the whole group.
module ustc_fan #(
    parameter int DW_DATA  = 8,
    parameter int DW_ROW   = 4,
    parameter int DW_CTRL  = 4,
    parameter int DW_LINE  = DW_DATA + DW_ROW + DW_CTRL,
    parameter int NUM_IN   = 32,
    parameter int N_LEVELS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*DW_LINE-1:0] in,
    output logic [NUM_IN*DW_LINE-1:0] out
);
    localparam int ROW_LSB = DW_DATA;
    localparam int CTL_LSB = DW_DATA + DW_ROW;
    localparam logic [DW_CTRL-1:0] CTRL_RES = DW_CTRL'(8);

    typedef logic [NUM_IN-1:0][DW_DATA-1:0] sum_vec_t;
    typedef logic [NUM_IN-1:0][DW_ROW-1:0]  row_vec_t;

    // s_in/f_in: running sums and "segment closed" flags entering each level
    // s_nx/f_nx: the same after that level's forwarding step
    // *_q: pipeline registers between levels (the last level feeds out)
    sum_vec_t          s_in   [N_LEVELS];
    sum_vec_t          s_nx   [N_LEVELS];
    sum_vec_t          s_q    [N_LEVELS-1];
    logic [NUM_IN-1:0] f_in   [N_LEVELS];
    logic [NUM_IN-1:0] f_nx   [N_LEVELS];
    logic [NUM_IN-1:0] f_q    [N_LEVELS-1];
    logic [NUM_IN-1:0] vs_in  [N_LEVELS];
    logic [NUM_IN-1:0] vs_q   [N_LEVELS-1];
    row_vec_t          row_in [N_LEVELS];
    row_vec_t          row_q  [N_LEVELS-1];

    logic [NUM_IN-1:0] unused_ctrl;
    logic              unused_flag;

    // Lane decode: invalid lanes contribute zero; a lane is a segment bottom
    // when it carries end, or when the lane just below opens a new group.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_dec
        logic [DW_CTRL-1:0] ctl;
        assign ctl            = in[i*DW_LINE+CTL_LSB +: DW_CTRL];
        assign s_in[0][i]     = ctl[3] ? in[i*DW_LINE +: DW_DATA] : '0;
        assign row_in[0][i]   = in[i*DW_LINE+ROW_LSB +: DW_ROW];
        assign vs_in[0][i]    = ctl[3] & ctl[1];
        assign unused_ctrl[i] = ^ctl;
        if (i == 0) begin : g_bot
            assign f_in[0][i] = 1'b1;
        end else begin : g_mid
            assign f_in[0][i] = ctl[0] | vs_in[0][i-1];
        end
    end

    // Forwarding levels: lane i pulls in lane i-2^l unless its segment is
    // already closed; lanes whose reach passed lane 0 are complete.
    for (genvar l = 0; l < N_LEVELS; l++) begin : g_lvl
        for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
            if (i >= (1 << l)) begin : g_fwd
                assign s_nx[l][i] = f_in[l][i] ? s_in[l][i]
                                               : s_in[l][i] + s_in[l][i-(1<<l)];
                assign f_nx[l][i] = f_in[l][i] | f_in[l][i-(1<<l)];
            end else begin : g_edge
                assign s_nx[l][i] = s_in[l][i];
                assign f_nx[l][i] = 1'b1;
            end
        end
        if (l > 0) begin : g_link
            assign s_in[l]   = s_q[l-1];
            assign f_in[l]   = f_q[l-1];
            assign vs_in[l]  = vs_q[l-1];
            assign row_in[l] = row_q[l-1];
        end
    end

    // The closed flag is not needed after the final level.
    assign unused_flag = ^f_nx[N_LEVELS-1];

    // Inter-level pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < N_LEVELS-1; l++) begin
                s_q[l]   <= '0;
                f_q[l]   <= '0;
                vs_q[l]  <= '0;
                row_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < N_LEVELS-1; l++) begin
                s_q[l]   <= s_nx[l];
                f_q[l]   <= f_nx[l];
                vs_q[l]  <= vs_in[l];
                row_q[l] <= row_in[l];
            end
        end
    end

    // Output register: only group start lanes carry a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                out[i*DW_LINE +: DW_LINE] <= vs_in[N_LEVELS-1][i]
                    ? {CTRL_RES, row_in[N_LEVELS-1][i], s_nx[N_LEVELS-1][i]}
                    : '0;
            end
        end
    end
endmodule

// File: tb/tb_ustc_fan.sv
// Testbench for ustc_fan: directed vectors with hand-computed results plus
// randomized vectors scored against a lane-walking reference model.
module tb_ustc_fan;
    localparam int N   = 32;
    localparam int LW  = 16;
    localparam int W   = N * LW;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_v;
    logic [W-1:0] out_v;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    ustc_fan dut (
        .clk (clk),
        .rst (rst),
        .in  (in_v),
        .out (out_v)
    );

    // Reference: walk lanes from the top, opening a group at each valid
    // start and closing it after any lane with end.
    function automatic logic [W-1:0] model(input logic [W-1:0] v);
        logic [W-1:0]  r;
        logic [LW-1:0] ln;
        bit            open;
        int            cur;
        r    = '0;
        open = 0;
        cur  = 0;
        for (int i = N-1; i >= 0; i--) begin
            ln = v[i*LW +: LW];
            if (ln[15] && ln[13]) begin
                open = 1;
                cur  = i;
                r[cur*LW +: LW] = {4'b1000, ln[11:8], 8'h00};
            end
            if (open) begin
                if (ln[15]) r[cur*LW +: 8] = r[cur*LW +: 8] + ln[7:0];
                if (ln[12]) open = 0;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] grp(input logic [W-1:0] v, input int top,
                                         input int bot, input logic [3:0] row,
                                         input int base, input bit idx_data);
        logic [3:0] c;
        int d;
        for (int i = bot; i <= top; i++) begin
            c = 4'b1000;
            if (i == top) c[1] = 1'b1;
            if (i == bot) c[0] = 1'b1;
            d = idx_data ? i : base + top - i;
            v[i*LW +: LW] = {c, row, 8'(d)};
        end
        return v;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        logic [3:0]   c;
        for (int k = 0; k < N; k++) begin
            c[3] = ($urandom_range(3) != 0);
            c[2] = $urandom_range(1);
            c[1] = ($urandom_range(4) == 0);
            c[0] = ($urandom_range(4) == 0);
            v[k*LW +: LW] = {c, 4'($urandom_range(15)), 8'($urandom_range(255))};
        end
        return v;
    endfunction

    // One cycle: check the result due now, then present the next vector.
    task automatic step(input logic [W-1:0] v, input string tag);
        logic [W-1:0] e;
        @(negedge clk);
        if (exp_q.size() == LAT) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (out_v !== e) begin
                n_err++;
                $display("FAIL %s: out=%h expected=%h", tag, out_v, e);
            end
        end
        in_v = v;
        exp_q.push_back(model(v));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst  = 1'b1;
        in_v = rand_vec();
        @(negedge clk);
        n_cmp++;
        if (out_v !== '0) begin
            n_err++;
            $display("FAIL %s: out=%h expected=0", tag, out_v);
        end
        rst  = 1'b0;
        in_v = '0;
        exp_q.delete();
        repeat (LAT) exp_q.push_back('0);
    endtask

    task automatic check_spec(input logic [W-1:0] e, input string tag);
        n_cmp++;
        if (out_v !== e) begin
            n_err++;
            $display("FAIL %s: out=%h expected=%h", tag, out_v, e);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
        repeat (LAT) step('0, "reset_idle");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v30, v31, e30, e31;
        v30 = '0;
        v30 = grp(v30, 31, 29, 4'd0, 0, 1);
        v30 = grp(v30, 28, 23, 4'd1, 0, 1);
        v30 = grp(v30, 22, 19, 4'd2, 0, 1);
        v30 = grp(v30, 18,  8, 4'd3, 0, 1);
        v30 = grp(v30,  7,  0, 4'd4, 0, 1);
        v31 = '0;
        v31 = grp(v31, 31, 24, 4'd4,  0, 0);
        v31 = grp(v31, 23, 13, 4'd3,  8, 0);
        v31 = grp(v31, 12,  9, 4'd2, 19, 0);
        v31 = grp(v31,  8,  3, 4'd1, 23, 0);
        v31 = grp(v31,  2,  0, 4'd0, 29, 0);
        e30 = '0;
        e30[31*LW +: LW] = 16'h805A;
        e30[28*LW +: LW] = 16'h8199;
        e30[22*LW +: LW] = 16'h8252;
        e30[18*LW +: LW] = 16'h838F;
        e30[ 7*LW +: LW] = 16'h841C;
        e31 = '0;
        e31[31*LW +: LW] = 16'h841C;
        e31[23*LW +: LW] = 16'h838F;
        e31[12*LW +: LW] = 16'h8252;
        e31[ 8*LW +: LW] = 16'h8199;
        e31[ 2*LW +: LW] = 16'h805A;
        step(v30, "descending");
        step(v31, "back_to_back");
        repeat (LAT-1) step('0, "b2b_drain");
        check_spec(e30, "descending_spec");
        step('0, "b2b_drain");
        check_spec(e31, "back_to_back_spec");
    endtask

    task automatic test_overflow();
        logic [W-1:0] v, e;
        v = '0;
        for (int i = 0; i < N; i++) v[i*LW +: LW] = {4'b1000, 4'h6, 8'hFF};
        v[31*LW + 13] = 1'b1;
        v[0*LW + 12]  = 1'b1;
        e = '0;
        e[31*LW +: LW] = {4'b1000, 4'h6, 8'hE0};
        step(v, "overflow");
        repeat (LAT) step('0, "overflow_drain");
        check_spec(e, "overflow_spec");
    endtask

    task automatic test_singletons();
        logic [W-1:0] v, vz, e;
        logic [3:0]   r;
        for (int i = 0; i < N; i++) begin
            r = 4'($urandom_range(15));
            v[i*LW +: LW]  = {4'b1011, r, 8'(i)};
            vz[i*LW +: LW] = {4'b0000, r, 8'(i)};
            e[i*LW +: LW]  = {4'b1000, r, 8'(i)};
        end
        step(v, "singletons");
        step(vz, "invalid_lanes");
        repeat (LAT-1) step('0, "single_drain");
        check_spec(e, "singletons_spec");
        step('0, "single_drain");
        check_spec('0, "invalid_lanes_spec");
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) step(rand_vec(), "random");
        repeat (LAT) step('0, "random_drain");
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] v;
        for (int k = 0; k < 3; k++) begin
            v = grp(rand_vec(), 31, 0, 4'd9, 0, 1);
            step(v, "inflight");
        end
        do_reset("mid_reset");
        for (int k = 0; k < LAT; k++) step('0, "post_reset_zero");
        for (int k = 0; k < 10; k++) step(rand_vec(), "post_reset_random");
        repeat (LAT) step('0, "post_reset_drain");
    endtask

    initial begin
        rst  = 1'b1;
        in_v = '0;
        test_reset();
        test_back_to_back();
        test_overflow();
        test_singletons();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
